// File: rtl/dmac_axi_sram_slave.sv
// AXI3 slave SRAM model: independent read and write engines, one outstanding
// burst each, word-addressed memory with byte strobes and SLVERR reporting.
module dmac_axi_sram_slave #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [3:0]  wid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i
);

  localparam int          IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [29:0] DEPTH_W     = 30'(MEM_DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_FIXED = 2'b00;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // Only 32-bit beats with FIXED or INCR bursts are supported.
  function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'b010) || burst[1];
  endfunction

  function automatic logic addr_bad(input logic [31:0] addr);
    return addr[31:2] >= DEPTH_W;
  endfunction

  // NOTE: the memory array has no reset; contents survive rst by design and a
  // reset loop over every word would not map onto an SRAM macro.
  logic [31:0] mem [MEM_DEPTH];

  // ---------------- read engine ----------------
  r_state_t    r_state_q, r_state_d;
  logic [31:0] r_addr_q, r_load_addr;
  logic [3:0]  r_len_q, r_load_len;
  logic [3:0]  r_cnt_q, r_load_cnt;
  logic        r_bad_q, r_load_bad;
  logic        r_fixed_q, r_load_fixed;
  logic        r_load, r_done, r_beat_err;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a variable unassigned (which would infer a latch).
  always_comb begin
    r_state_d    = r_state_q;
    r_load       = 1'b0;
    r_done       = 1'b0;
    r_load_addr  = r_addr_q;
    r_load_cnt   = r_cnt_q;
    r_load_len   = r_len_q;
    r_load_bad   = r_bad_q;
    r_load_fixed = r_fixed_q;
    case (r_state_q)
      R_IDLE: if (arvalid_i) begin
        r_state_d    = R_DATA;
        r_load       = 1'b1;
        r_load_addr  = araddr_i;
        r_load_cnt   = '0;
        r_load_len   = arlen_i;
        r_load_bad   = burst_bad(arsize_i, arburst_i);
        r_load_fixed = (arburst_i == BURST_FIXED);
      end
      R_DATA: if (rready_i) begin
        if (r_cnt_q == r_len_q) begin
          r_state_d = R_IDLE;
          r_done    = 1'b1;
        end else begin
          r_load      = 1'b1;
          r_load_addr = r_fixed_q ? r_addr_q : r_addr_q + 32'd4;
          r_load_cnt  = r_cnt_q + 4'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    r_beat_err = r_load_bad || addr_bad(r_load_addr);
  end

  // NOTE: non-blocking assignments here make a same-cycle write to the word
  // being loaded invisible to this read (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_bad_q   <= 1'b0;
      r_fixed_q <= 1'b0;
      rid_o     <= '0;
      rdata_o   <= '0;
      rresp_o   <= RESP_OKAY;
      rlast_o   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      if (r_state_q == R_IDLE && arvalid_i) rid_o <= arid_i;
      if (r_load) begin
        r_addr_q  <= r_load_addr;
        r_len_q   <= r_load_len;
        r_cnt_q   <= r_load_cnt;
        r_bad_q   <= r_load_bad;
        r_fixed_q <= r_load_fixed;
        rdata_o   <= r_beat_err ? '0 : mem[r_load_addr[IDX_W+1:2]];
        rresp_o   <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
        rlast_o   <= (r_load_cnt == r_load_len);
      end else if (r_done) begin
        rlast_o <= 1'b0;
      end
    end
  end

  assign arready_o = (r_state_q == R_IDLE);
  assign rvalid_o  = (r_state_q == R_DATA);

  // ---------------- write engine ----------------
  w_state_t    w_state_q, w_state_d;
  logic [31:0] w_addr_q;
  logic [3:0]  w_id_q, w_len_q, w_cnt_q;
  logic        w_bad_q, w_fixed_q, w_err_q;
  logic        w_accept, w_advance, w_err_set, w_beat_bad, mem_we;

  always_comb begin
    w_state_d  = w_state_q;
    w_accept   = 1'b0;
    w_advance  = 1'b0;
    w_err_set  = 1'b0;
    w_beat_bad = 1'b0;
    mem_we     = 1'b0;
    case (w_state_q)
      W_IDLE: if (awvalid_i) begin
        w_state_d = W_DATA;
        w_accept  = 1'b1;
      end
      W_DATA: if (wvalid_i) begin
        w_beat_bad = w_bad_q || addr_bad(w_addr_q) || (wid_i != w_id_q);
        mem_we     = !w_beat_bad && !rst;
        // A last flag that disagrees with the beat count is a protocol error.
        w_err_set  = w_beat_bad || ((w_cnt_q == w_len_q) != wlast_i);
        if (wlast_i || w_cnt_q == w_len_q) w_state_d = W_RESP;
        else                               w_advance = 1'b1;
      end
      W_RESP: if (bready_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_bad_q   <= 1'b0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      if (w_accept) begin
        w_addr_q  <= awaddr_i;
        w_id_q    <= awid_i;
        w_len_q   <= awlen_i;
        w_cnt_q   <= '0;
        w_bad_q   <= burst_bad(awsize_i, awburst_i);
        w_fixed_q <= (awburst_i == BURST_FIXED);
        w_err_q   <= 1'b0;
      end
      if (w_advance) begin
        w_addr_q <= w_fixed_q ? w_addr_q : w_addr_q + 32'd4;
        w_cnt_q  <= w_cnt_q + 4'd1;
      end
      if (w_err_set) w_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem[w_addr_q[IDX_W+1:2]][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign awready_o = (w_state_q == W_IDLE);
  assign wready_o  = (w_state_q == W_DATA);
  assign bvalid_o  = (w_state_q == W_RESP);
  assign bid_o     = w_id_q;
  assign bresp_o   = w_err_q ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_dmac_axi_sram_slave.sv
// Scoreboard bench for dmac_axi_sram_slave: stimulus pushes expected R/B
// responses, a negedge monitor pops and compares them on each handshake.
module tb_dmac_axi_sram_slave;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid_i, wid_i, arid_i, bid_o, rid_o;
  logic [31:0] awaddr_i, araddr_i, wdata_i, rdata_o;
  logic [3:0]  awlen_i, arlen_i, wstrb_i;
  logic [2:0]  awsize_i, arsize_i;
  logic [1:0]  awburst_i, arburst_i, bresp_o, rresp_o;
  logic        awvalid_i, awready_o, wlast_i, wvalid_i, wready_o;
  logic        bvalid_o, bready_i, arvalid_i, arready_o;
  logic        rlast_o, rvalid_o, rready_i;

  dmac_axi_sram_slave #(.MEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t      rq[$];
  b_exp_t      bq[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] wbuf[16];
  logic [31:0] rbuf[16];
  logic [1:0]  rresp_buf[16];
  logic [3:0]  rr_pat = 4'b1001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- monitor ----------------
  logic        stall_q = 1'b0;
  logic [39:0] stall_val;
  r_exp_t      re;
  b_exp_t      be;

  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) check("r_stable", {rvalid_o, rid_o, rdata_o, rresp_o, rlast_o}, stall_val);
      if (rvalid_o && rready_i) begin
        if (rq.size() == 0) check("r_extra_beat", 64'(rq.size()), 64'd1);
        else begin
          re = rq.pop_front();
          check("r_beat", {rid_o, rdata_o, rresp_o, rlast_o}, {re.id, re.data, re.resp, re.last});
        end
      end
      stall_q   = rvalid_o && !rready_i;
      stall_val = {1'b1, rid_o, rdata_o, rresp_o, rlast_o};
      if (bvalid_o && bready_i) begin
        if (bq.size() == 0) check("b_extra", 64'(bq.size()), 64'd1);
        else begin
          be = bq.pop_front();
          check("b_resp", {bid_o, bresp_o}, {be.id, be.resp});
        end
      end
    end
  end

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    logic hs;
    hs = 1'b0;
    awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst;
    awvalid_i = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = awready_o;
      @(posedge clk); #1;
    end
    awvalid_i = 1'b0;
    if (!hs) check("aw_handshake", 64'(hs), 64'd1);
  endtask

  task automatic do_w(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                      input logic last);
    logic hs;
    hs = 1'b0;
    wid_i = id; wdata_i = data; wstrb_i = strb; wlast_i = last;
    wvalid_i = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = wready_o;
      @(posedge clk); #1;
    end
    wvalid_i = 1'b0;
    wlast_i  = 1'b0;
    if (!hs) check("w_handshake", 64'(hs), 64'd1);
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [1:0] burst);
    logic hs;
    hs = 1'b0;
    arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = 3'b010; arburst_i = burst;
    arvalid_i = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk); hs = arready_o;
      @(posedge clk); #1;
    end
    arvalid_i = 1'b0;
    if (!hs) check("ar_handshake", 64'(hs), 64'd1);
  endtask

  task automatic write_burst(input logic [3:0] awid, input logic [3:0] wid, input logic [31:0] addr,
                             input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input int nbeats, input logic [3:0] strb, input logic drop_last,
                             input logic [1:0] exp_resp);
    b_exp_t e;
    e.id = awid; e.resp = exp_resp;
    bq.push_back(e);
    do_aw(awid, addr, len, size, burst);
    for (int b = 0; b < nbeats; b++) do_w(wid, wbuf[b], strb, (b == nbeats - 1) && !drop_last);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic toggle);
    r_exp_t e;
    for (int i = 0; i <= int'(len); i++) begin
      e.id = id; e.data = rbuf[i]; e.resp = rresp_buf[i]; e.last = (i == int'(len));
      rq.push_back(e);
    end
    rready_i = 1'b1;
    do_ar(id, addr, len, burst);
    @(negedge clk);
    check("r_latency", 64'(rvalid_o), 64'd1);
    @(posedge clk); #1;
    if (toggle) begin
      for (int c = 1; c < 200 && rq.size() != 0; c++) begin
        rready_i = rr_pat[c % 4];
        @(posedge clk); #1;
      end
    end
    rready_i = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (rq.size() != 0 || bq.size() != 0); i++) @(posedge clk);
    @(posedge clk); #1;
    check("r_drain", 64'(rq.size()), 64'd0);
    check("b_drain", 64'(bq.size()), 64'd0);
  endtask

  task automatic set_rexp(input int n, input logic [31:0] base, input logic [1:0] resp);
    for (int i = 0; i < n; i++) begin
      rbuf[i] = base + 32'(i); rresp_buf[i] = resp;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awvalid_i = 1'b0;
    wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b1;
    arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0; arvalid_i = 1'b0;
    rready_i = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 64'(awready_o), 64'd1);
    check("rst_arready", 64'(arready_o), 64'd1);
    check("rst_wready",  64'(wready_o),  64'd0);
    check("rst_bvalid",  64'(bvalid_o),  64'd0);
    check("rst_rvalid",  64'(rvalid_o),  64'd0);
    check("rst_rlast",   64'(rlast_o),   64'd0);
    check("rst_ids",     64'({bid_o, rid_o}), 64'd0);
    check("rst_rdata",   64'(rdata_o),   64'd0);
    check("rst_resps",   64'({bresp_o, rresp_o}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // INCR write then read back, plain and with rready stalls
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    write_burst(4'd2, 4'd2, 32'h100, 4'd3, 3'b010, INCR, 4, 4'hF, 1'b0, OKAY);
    drain();
    for (int i = 0; i < 4; i++) begin rbuf[i] = wbuf[i]; rresp_buf[i] = OKAY; end
    read_burst(4'd2, 32'h100, 4'd3, INCR, 1'b0);
    drain();
    read_burst(4'd2, 32'h100, 4'd3, INCR, 1'b1);
    drain();

    // partial strobe: 0xAABBCCDD merged with 0x11223344 under 4'b0101
    wbuf[0] = 32'hAABBCCDD;
    write_burst(4'd0, 4'd0, 32'h40, 4'd0, 3'b010, INCR, 1, 4'hF, 1'b0, OKAY);
    wbuf[0] = 32'h11223344;
    write_burst(4'd0, 4'd0, 32'h40, 4'd0, 3'b010, INCR, 1, 4'b0101, 1'b0, OKAY);
    drain();
    rbuf[0] = 32'hAA22CC44; rresp_buf[0] = OKAY;
    read_burst(4'd5, 32'h40, 4'd0, INCR, 1'b0);
    drain();

    // beat 1 crosses the top of memory
    wbuf[0] = 32'hA5A5A5A5; wbuf[1] = 32'h5A5A5A5A;
    write_burst(4'd9, 4'd9, 32'hFFC, 4'd1, 3'b010, INCR, 2, 4'hF, 1'b0, SLVERR);
    drain();
    rbuf[0] = 32'hA5A5A5A5; rresp_buf[0] = OKAY;
    rbuf[1] = 32'h0;        rresp_buf[1] = SLVERR;
    read_burst(4'd9, 32'hFFC, 4'd1, INCR, 1'b0);
    drain();

    // protocol errors must not disturb existing data at 0x200
    wbuf[0] = 32'hCAFE0000; wbuf[1] = 32'hCAFE0001;
    write_burst(4'd1, 4'd1, 32'h200, 4'd1, 3'b010, INCR, 2, 4'hF, 1'b0, OKAY);
    wbuf[0] = 32'hDEAD0000; wbuf[1] = 32'hDEAD0001;
    write_burst(4'd1, 4'd1, 32'h200, 4'd1, 3'b010, WRAP, 2, 4'hF, 1'b0, SLVERR);
    write_burst(4'd1, 4'd1, 32'h200, 4'd0, 3'b001, INCR, 1, 4'hF, 1'b0, SLVERR);
    write_burst(4'd3, 4'd4, 32'h204, 4'd0, 3'b010, INCR, 1, 4'hF, 1'b0, SLVERR);
    drain();
    rbuf[0] = 32'hCAFE0000; rbuf[1] = 32'hCAFE0001; rresp_buf[0] = OKAY; rresp_buf[1] = OKAY;
    read_burst(4'd1, 32'h200, 4'd1, INCR, 1'b0);
    drain();

    // early wlast on beat 1 of a 4-beat burst; missing wlast on the final beat
    wbuf[0] = 32'h30300000; wbuf[1] = 32'h30300001;
    write_burst(4'd6, 4'd6, 32'h300, 4'd3, 3'b010, INCR, 2, 4'hF, 1'b0, SLVERR);
    wbuf[0] = 32'h31000000;
    write_burst(4'd6, 4'd6, 32'h310, 4'd0, 3'b010, INCR, 1, 4'hF, 1'b1, SLVERR);
    drain();
    rbuf[0] = 32'h30300000; rbuf[1] = 32'h30300001; rresp_buf[0] = OKAY; rresp_buf[1] = OKAY;
    read_burst(4'd6, 32'h300, 4'd1, INCR, 1'b0);
    rbuf[0] = 32'h31000000;
    read_burst(4'd6, 32'h310, 4'd0, INCR, 1'b0);
    drain();

    // FIXED bursts hold the address; WRAP reads are SLVERR with zero data
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
    write_burst(4'd8, 4'd8, 32'h400, 4'd2, 3'b010, FIXED, 3, 4'hF, 1'b0, OKAY);
    drain();
    rbuf[0] = 32'h3; rbuf[1] = 32'h3; rresp_buf[0] = OKAY; rresp_buf[1] = OKAY;
    read_burst(4'd8, 32'h400, 4'd1, FIXED, 1'b0);
    drain();
    rbuf[0] = 32'h0; rbuf[1] = 32'h0; rresp_buf[0] = SLVERR; rresp_buf[1] = SLVERR;
    read_burst(4'd7, 32'h100, 4'd1, WRAP, 1'b0);
    drain();

    // concurrent 16-beat read and 16-beat write to disjoint regions
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h60000000 + 32'(i);
    write_burst(4'd4, 4'd4, 32'h600, 4'hF, 3'b010, INCR, 16, 4'hF, 1'b0, OKAY);
    drain();
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h80000000 + 32'(i);
    set_rexp(16, 32'h60000000, OKAY);
    fork
      write_burst(4'd10, 4'd10, 32'h800, 4'hF, 3'b010, INCR, 16, 4'hF, 1'b0, OKAY);
      read_burst(4'd11, 32'h600, 4'hF, INCR, 1'b0);
    join
    drain();
    set_rexp(16, 32'h80000000, OKAY);
    read_burst(4'd12, 32'h800, 4'hF, INCR, 1'b0);
    drain();

    // reset in the middle of a write burst: no B, completed beats retained
    do_aw(4'd13, 32'hA00, 4'd3, 3'b010, INCR);
    do_w(4'd13, 32'h0A0A0001, 4'hF, 1'b0);
    do_w(4'd13, 32'h0A0A0002, 4'hF, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_awready", 64'(awready_o), 64'd1);
    check("rst_mid_wready",  64'(wready_o),  64'd0);
    check("rst_mid_bvalid",  64'(bvalid_o),  64'd0);
    @(posedge clk); #1;
    rbuf[0] = 32'h0A0A0001; rbuf[1] = 32'h0A0A0002; rresp_buf[0] = OKAY; rresp_buf[1] = OKAY;
    read_burst(4'd13, 32'hA00, 4'd1, INCR, 1'b0);
    rbuf[0] = 32'h11111111;
    read_burst(4'd14, 32'h100, 4'd0, INCR, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmac_axi_sram_slave.md
Name: dmac_axi_sram_slave

Overview:
- AXI3 slave (responder) memory model: the far end of the DMAC AXI master port.
- Accepts AR/AW/W, returns R/B with the transaction ID echoed; backs a word-addressed SRAM array.
- Used as the memory target in DMAC system benches and as an on-chip scratch SRAM.
- Independent read and write engines, one outstanding transaction each.

Parameters:
MEM_DEPTH, 1024, number of 32-bit words; valid byte addresses are 0 .. 4*MEM_DEPTH-1

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
awid_i  input  4  write ID
awaddr_i  input  32  write start byte address
awlen_i  input  4  beats-1
awsize_i  input  3  beat size
awburst_i  input  2  burst type
awvalid_i  input  1  AW valid
awready_o  output  1  AW ready
wid_i  input  4  W ID
wdata_i  input  32  write data
wstrb_i  input  4  byte strobes
wlast_i  input  1  last beat
wvalid_i  input  1  W valid
wready_o  output  1  W ready
bid_o  output  4  B ID
bresp_o  output  2  write response
bvalid_o  output  1  B valid
bready_i  input  1  B ready
arid_i  input  4  read ID
araddr_i  input  32  read start byte address
arlen_i  input  4  beats-1
arsize_i  input  3  beat size
arburst_i  input  2  burst type
arvalid_i  input  1  AR valid
arready_o  output  1  AR ready
rid_o  output  4  R ID
rdata_o  output  32  read data
rresp_o  output  2  read response
rlast_o  output  1  last beat
rvalid_o  output  1  R valid
rready_i  input  1  R ready

Behaviour:
- Reset (rst=1 at posedge): both FSMs to IDLE; awready_o=1, arready_o=1, wready_o=0, bvalid_o=0, rvalid_o=0, rlast_o=0, bid_o/rid_o/rdata_o=0, bresp_o/rresp_o=2'b00. SRAM contents are not cleared. Reset mid-burst abandons the burst silently (no B/R issued).
- Burst legality: awsize/arsize must be 3'b010; burst 2'b01 INCR (addr += 4 per beat) and 2'b00 FIXED (addr held) are legal; 2'b10 WRAP and 2'b11 are illegal. Illegal burst -> SLVERR (2'b10) for the whole burst.
- Beat address range check: word index = addr[31:2]; out of range if >= MEM_DEPTH -> that beat is SLVERR. Addresses are 32-bit; increment wraps modulo 2^32 (no 4KB check).
- Read FSM: R_IDLE (arready_o=1) -> on arvalid&&arready latch id/addr/len/burst, load beat 0 into rdata_o, go R_DATA; rvalid_o=1 the cycle after AR handshake (latency 1).
- R_DATA: arready_o=0; rdata_o/rresp_o/rlast_o held stable while rvalid_o&&!rready_i. On handshake: if beat count==len -> rvalid_o=0, R_IDLE (arready_o=1 next cycle); else next beat loaded the following cycle with no bubble (rvalid_o stays 1). rlast_o=1 only on beat len. SLVERR beats return rdata_o=0.
- Write FSM: W_IDLE (awready_o=1) -> on AW handshake latch id/addr/len/burst, clear error flag, W_DATA.
- W_DATA: wready_o=1, awready_o=0. Each W handshake writes bytes with wstrb_i=1 to mem[addr], unless burst illegal, beat out of range, or wid_i != latched awid; any of these sets error flag and suppresses that beat's write. Beat count reaching len with wlast_i=0, or wlast_i=1 before beat len, sets error flag. Burst ends on wlast_i=1 or beat count==len, whichever first -> W_RESP.
- W_RESP: wready_o=0, bvalid_o=1, bid_o=latched id, bresp_o = error ? 2'b10 : 2'b00; held until bready_i; then W_IDLE.
- Simultaneous read load and write to the same word in one cycle: read returns the old data (read-before-write). Write of beat N is visible to any read load in a later cycle.
- Read and write engines operate fully concurrently; AW acceptance does not depend on read state and vice versa.
- Data may be offered on W before AW; wready_o=0 in W_IDLE, so master must wait.

Test Plan:
- Write INCR awid=2, awaddr=0x100, awlen=3, data 0x11111111..0x44444444, wstrb=4'hF -> 4 beats accepted, B: bid=2, bresp=00; then read arid=2 same range -> rdata 0x11111111..0x44444444, rlast on beat 4, rid=2, rresp=00.
- Read with rready toggling 1,0,0,1 each beat -> rdata/rlast/rresp held stable during stalls; no beat lost or duplicated; first rvalid exactly 1 cycle after AR handshake.
- Partial strobe: mem[0x40]=0xAABBCCDD, write 0x11223344 wstrb=4'b0101 -> read 0xAA22CC44.
- Out-of-range: MEM_DEPTH=1024, write awaddr=0xFFC awlen=1 -> beat 0 written, beat 1 dropped, bresp=10; read same -> rresp 00 then 10, second rdata=0.
- Protocol errors: WRAP burst, awsize=3'b001, wid!=awid, or wlast early at beat 1 of awlen=3 -> bresp=10, illegal-burst writes suppressed, FSM returns to W_IDLE.
- Concurrency/reset: simultaneous 16-beat read and 16-beat write to disjoint regions complete with correct data; rst=1 mid-write-burst -> awready_o=1, wready_o=0, bvalid_o=0 next cycle, previously written words retained.
